// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for a multicycle RV32I core.
// Decodes the latched instruction fields and sequences the shared ALU, the
// instruction/data memory port, the register file and the immediate extender
// over 3 to 5 cycles per instruction. Stalls on a single mem_ready handshake.
//
// Build option: define CTRL_UTYPE_EN to build the EXECU state (lui/auipc).
// Without it, lui/auipc take the illegal path and ImmSrc never reports U.
//
// Parameters:
//   RESET_PC_HOLD  WAIT cycles after reset release before the first fetch (0-3).
//                  Reset always lands in WAIT, so 0 and 1 both give one WAIT cycle.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   op, funct3, funct7b5   instruction fields from the IR
//   Zero                   ALU zero flag (branch decision)
//   mem_ready              memory completes the current access this cycle
//   mem_req                memory access requested
//   PCWrite, IRWrite, RegWrite, MemWrite   write enables
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB    datapath mux selects
//   ImmSrc                 immediate extender format (follows op in every state)
//   ALUControl             ALU operation
//   retire                 one-cycle pulse when an instruction completes
//   illegal                one-cycle pulse when DECODE sees an unsupported opcode
// All outputs are combinational from the state register and the inputs.
module multicycle_controller #(
   parameter int unsigned RESET_PC_HOLD = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       retire,
   output logic       illegal
);

   localparam int unsigned CNT_W = 2;
   // Last WAIT count value before moving to FETCH.
   localparam logic [CNT_W-1:0] HOLD_LAST =
      CNT_W'((RESET_PC_HOLD == 0) ? 0 : RESET_PC_HOLD - 1);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
`ifdef CTRL_UTYPE_EN
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
`endif

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [3:0] {
      S_WAIT,
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
`ifdef CTRL_UTYPE_EN
      S_EXECU,
`endif
      S_BEQ,
      S_JAL
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       alu_funct_c;

   // State register and post-reset hold counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_WAIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Extender format straight from the opcode, independent of state.
   always_comb begin
      ImmSrc = 3'b000;
      case (op)
         OP_LOAD, OP_ITYPE, OP_JALR: ImmSrc = 3'b000;
         OP_STORE:                   ImmSrc = 3'b001;
         OP_BRANCH:                  ImmSrc = 3'b010;
         OP_JAL:                     ImmSrc = 3'b011;
`ifdef CTRL_UTYPE_EN
         OP_LUI, OP_AUIPC:           ImmSrc = 3'b100;
`endif
         default:                    ImmSrc = 3'b000;
      endcase
   end

   // ALU operation for EXECR/EXECI; sub only exists for register-register ops.
   always_comb begin
      alu_funct_c = ALU_ADD;
      case (funct3)
         3'b000:  alu_funct_c = (state_q == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_funct_c = ALU_SLT;
         3'b110:  alu_funct_c = ALU_OR;
         3'b111:  alu_funct_c = ALU_AND;
         default: alu_funct_c = ALU_ADD;
      endcase
   end

   // Next-state and datapath control.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mem_req    = 1'b0;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      retire     = 1'b0;
      illegal    = 1'b0;

      case (state_q)
         S_WAIT: begin
            if (cnt_q == HOLD_LAST) state_d = S_FETCH;
            else                    cnt_d   = cnt_q + CNT_W'(1);
         end

         // PC + 4 is written back as the instruction lands in the IR.
         S_FETCH: begin
            mem_req   = 1'b1;
            AdrSrc    = 1'b0;
            ALUSrcA   = 2'b00;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = mem_ready;
            PCWrite   = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end

         // OldPC + imm precomputes the branch/jump target into ALUOut.
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BEQ;
               OP_JAL:            state_d = S_JAL;
`ifdef CTRL_UTYPE_EN
               OP_LUI, OP_AUIPC:  state_d = S_EXECU;
`endif
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end

         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end

         S_MEMREAD: begin
            mem_req   = 1'b1;
            AdrSrc    = 1'b1;
            ResultSrc = 2'b00;
            if (mem_ready) state_d = S_MEMWB;
         end

         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end

         S_MEMWRITE: begin
            mem_req   = 1'b1;
            AdrSrc    = 1'b1;
            ResultSrc = 2'b00;
            MemWrite  = mem_ready;
            retire    = mem_ready;
            if (mem_ready) state_d = S_FETCH;
         end

         S_EXECR: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b00;
            ALUControl = alu_funct_c;
            state_d    = S_ALUWB;
         end

         S_EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_funct_c;
            state_d    = S_ALUWB;
         end

         S_ALUWB: begin
            ResultSrc = 2'b00;
            RegWrite  = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end

         // Compare rs1 - rs2; taken branch loads the target held in ALUOut.
         S_BEQ: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b00;
            ALUControl = ALU_SUB;
            ResultSrc  = 2'b00;
            PCWrite    = Zero;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end

         // Jump to ALUOut while computing OldPC + 4 for the link register.
         S_JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b00;
            PCWrite   = 1'b1;
            state_d   = S_ALUWB;
         end

`ifdef CTRL_UTYPE_EN
         // lui adds the immediate to zero, auipc to OldPC.
         S_EXECU: begin
            ALUSrcA = (op == OP_LUI) ? 2'b11 : 2'b01;
            ALUSrcB = 2'b01;
            state_d = S_ALUWB;
         end
`endif

         default: state_d = S_WAIT;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control words.
`timescale 1ns/1ps
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [6:0] op = 7'b0000011;
   logic [2:0] funct3 = 3'b000;
   logic       funct7b5 = 1'b0;
   logic       Zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ImmSrc, ALUControl;
   logic       retire, illegal;

   int vectors = 0;
   int miscompares = 0;

   multicycle_controller #(.RESET_PC_HOLD(1)) dut (
      .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl), .retire(retire), .illegal(illegal)
   );

   always #10 clk = ~clk;

   // {mem_req,PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,retire,illegal}
   wire [19:0] outs = {mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
                       ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, retire, illegal};

   function automatic logic [19:0] mk(input logic [5:0] en, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] imm, input logic [2:0] alu,
                                      input logic [1:0] pulse);
      return {en, rs, sa, sb, imm, alu, pulse};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [19:0] e;
      #2 reset_n = 1'b0;
      op = 7'b0000011;
      mem_ready = 1'b1;
      tick();
      tick();
      e = mk(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00);
      vectors++;
      if (outs !== e) begin miscompares++; $display("FAIL reset_idle: got %05h expected %05h", outs, e); end
      op = 7'b1100011;
      #1;
      e = mk(6'b000000, 2'b00, 2'b00, 2'b00, 3'b010, 3'b000, 2'b00);
      vectors++;
      if (outs !== e) begin miscompares++; $display("FAIL reset_immsrc: got %05h expected %05h", outs, e); end
      op = 7'b0000011;
      reset_n = 1'b1;
      @(negedge clk);
      e = mk(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00);
      vectors++;
      if (outs !== e) begin miscompares++; $display("FAIL reset_wait: got %05h expected %05h", outs, e); end
      tick();
      @(negedge clk);
      e = mk(6'b111000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
      vectors++;
      if (outs !== e) begin miscompares++; $display("FAIL reset_first_fetch: got %05h expected %05h", outs, e); end
      mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_load();
      logic [19:0] ev[8];
      logic        rdy[8];
      op = 7'b0000011; funct3 = 3'b010;
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      ev[0] = mk(6'b111000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
      ev[1] = mk(6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 2'b00);
      ev[2] = mk(6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 2'b00);
      ev[3] = mk(6'b100001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00);
      ev[4] = ev[3];
      ev[5] = ev[3];
      ev[6] = mk(6'b000100, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 2'b10);
      ev[7] = mk(6'b100000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
      for (int i = 0; i < 8; i++) begin
         mem_ready = rdy[i];
         @(negedge clk);
         vectors++;
         if (outs !== ev[i]) begin miscompares++; $display("FAIL load cycle %0d: got %05h expected %05h", i, outs, ev[i]); end
         tick();
      end
   endtask

   task automatic test_rtype();
      logic [19:0] ev[5];
      logic        rdy[5];
      logic [2:0]  f3s[5];
      logic        f7s[5];
      logic [2:0]  alus[5];
      logic [19:0] e;
      op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
      rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      f3s  = '{3'b010, 3'b110, 3'b111, 3'b001, 3'b000};
      f7s  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      alus = '{3'b101, 3'b011, 3'b010, 3'b000, 3'b000};
      ev[0] = mk(6'b111000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
      ev[1] = mk(6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 2'b00);
      ev[2] = mk(6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 2'b00);
      ev[3] = mk(6'b000100, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b10);
      ev[4] = mk(6'b100000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
      for (int i = 0; i < 5; i++) begin
         mem_ready = rdy[i];
         @(negedge clk);
         vectors++;
         if (outs !== ev[i]) begin miscompares++; $display("FAIL rtype cycle %0d: got %05h expected %05h", i, outs, ev[i]); end
         if (i == 2) begin
            for (int j = 0; j < 5; j++) begin
               funct3 = f3s[j]; funct7b5 = f7s[j];
               #1;
               e = mk(6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, alus[j], 2'b00);
               vectors++;
               if (outs !== e) begin miscompares++; $display("FAIL rtype_alu f3=%b: got %05h expected %05h", f3s[j], outs, e); end
            end
            funct3 = 3'b000; funct7b5 = 1'b1;
         end
         tick();
      end
   endtask

   task automatic test_itype();
      logic [19:0] ev[5];
      logic [19:0] e;
      op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
      ev[0] = mk(6'b111000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
      ev[1] = mk(6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 2'b00);
      ev[2] = mk(6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 2'b00);
      ev[3] = mk(6'b000100, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b10);
      ev[4] = mk(6'b100000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
      for (int i = 0; i < 5; i++) begin
         mem_ready = (i == 4) ? 1'b0 : 1'b1;
         @(negedge clk);
         vectors++;
         if (outs !== ev[i]) begin miscompares++; $display("FAIL itype cycle %0d: got %05h expected %05h", i, outs, ev[i]); end
         if (i == 2) begin
            funct3 = 3'b110;
            #1;
            e = mk(6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b011, 2'b00);
            vectors++;
            if (outs !== e) begin miscompares++; $display("FAIL itype_or: got %05h expected %05h", outs, e); end
            funct3 = 3'b000;
         end
         tick();
      end
   endtask

   task automatic test_beq(input logic z);
      logic [19:0] ev[4];
      op = 7'b1100011; Zero = z;
      ev[0] = mk(6'b111000, 2'b10, 2'b00, 2'b10, 3'b010, 3'b000, 2'b00);
      ev[1] = mk(6'b000000, 2'b00, 2'b01, 2'b01, 3'b010, 3'b000, 2'b00);
      ev[2] = mk({1'b0, z, 4'b0000}, 2'b00, 2'b10, 2'b00, 3'b010, 3'b001, 2'b10);
      ev[3] = mk(6'b100000, 2'b10, 2'b00, 2'b10, 3'b010, 3'b000, 2'b00);
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 3) ? 1'b0 : 1'b1;
         @(negedge clk);
         vectors++;
         if (outs !== ev[i]) begin miscompares++; $display("FAIL beq zero=%0b cycle %0d: got %05h expected %05h", z, i, outs, ev[i]); end
         tick();
      end
      Zero = 1'b0;
   endtask

   task automatic test_jal();
      logic [19:0] ev[5];
      op = 7'b1101111;
      ev[0] = mk(6'b111000, 2'b10, 2'b00, 2'b10, 3'b011, 3'b000, 2'b00);
      ev[1] = mk(6'b000000, 2'b00, 2'b01, 2'b01, 3'b011, 3'b000, 2'b00);
      ev[2] = mk(6'b010000, 2'b00, 2'b01, 2'b10, 3'b011, 3'b000, 2'b00);
      ev[3] = mk(6'b000100, 2'b00, 2'b00, 2'b00, 3'b011, 3'b000, 2'b10);
      ev[4] = mk(6'b100000, 2'b10, 2'b00, 2'b10, 3'b011, 3'b000, 2'b00);
      for (int i = 0; i < 5; i++) begin
         mem_ready = (i == 4) ? 1'b0 : 1'b1;
         @(negedge clk);
         vectors++;
         if (outs !== ev[i]) begin miscompares++; $display("FAIL jal cycle %0d: got %05h expected %05h", i, outs, ev[i]); end
         tick();
      end
   endtask

   task automatic test_utype();
      logic [19:0] ev[5];
      int n;
      op = 7'b0110111;
`ifdef CTRL_UTYPE_EN
      n = 5;
      ev[0] = mk(6'b111000, 2'b10, 2'b00, 2'b10, 3'b100, 3'b000, 2'b00);
      ev[1] = mk(6'b000000, 2'b00, 2'b01, 2'b01, 3'b100, 3'b000, 2'b00);
      ev[2] = mk(6'b000000, 2'b00, 2'b11, 2'b01, 3'b100, 3'b000, 2'b00);
      ev[3] = mk(6'b000100, 2'b00, 2'b00, 2'b00, 3'b100, 3'b000, 2'b10);
      ev[4] = mk(6'b100000, 2'b10, 2'b00, 2'b10, 3'b100, 3'b000, 2'b00);
`else
      n = 3;
      ev[0] = mk(6'b111000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
      ev[1] = mk(6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 2'b01);
      ev[2] = mk(6'b100000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
      ev[3] = '0;
      ev[4] = '0;
`endif
      for (int i = 0; i < n; i++) begin
         mem_ready = (i == n - 1) ? 1'b0 : 1'b1;
         @(negedge clk);
         vectors++;
         if (outs !== ev[i]) begin miscompares++; $display("FAIL lui cycle %0d: got %05h expected %05h", i, outs, ev[i]); end
         tick();
      end
   endtask

   task automatic test_illegal();
      logic [19:0] ev[3];
      op = 7'b1111111;
      ev[0] = mk(6'b111000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
      ev[1] = mk(6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 2'b01);
      ev[2] = mk(6'b100000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
      for (int i = 0; i < 3; i++) begin
         mem_ready = (i == 2) ? 1'b0 : 1'b1;
         @(negedge clk);
         vectors++;
         if (outs !== ev[i]) begin miscompares++; $display("FAIL illegal cycle %0d: got %05h expected %05h", i, outs, ev[i]); end
         tick();
      end
   endtask

   task automatic test_store();
      logic [19:0] ev[6];
      logic        rdy[6];
      op = 7'b0100011;
      rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      ev[0] = mk(6'b111000, 2'b10, 2'b00, 2'b10, 3'b001, 3'b000, 2'b00);
      ev[1] = mk(6'b000000, 2'b00, 2'b01, 2'b01, 3'b001, 3'b000, 2'b00);
      ev[2] = mk(6'b000000, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 2'b00);
      ev[3] = mk(6'b100001, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 2'b00);
      ev[4] = mk(6'b100011, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 2'b10);
      ev[5] = mk(6'b100000, 2'b10, 2'b00, 2'b10, 3'b001, 3'b000, 2'b00);
      for (int i = 0; i < 6; i++) begin
         mem_ready = rdy[i];
         @(negedge clk);
         vectors++;
         if (outs !== ev[i]) begin miscompares++; $display("FAIL store cycle %0d: got %05h expected %05h", i, outs, ev[i]); end
         tick();
      end
   endtask

   task automatic test_reset_midwrite();
      logic [19:0] e;
      logic [19:0] zero_v;
      op = 7'b0100011;
      zero_v = mk(6'b000000, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 2'b00);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      tick();
      @(negedge clk);
      e = mk(6'b100001, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 2'b00);
      vectors++;
      if (outs !== e) begin miscompares++; $display("FAIL midwrite_pre: got %05h expected %05h", outs, e); end
      #1 reset_n = 1'b0;
      #1;
      vectors++;
      if (outs !== zero_v) begin miscompares++; $display("FAIL midwrite_reset: got %05h expected %05h", outs, zero_v); end
      mem_ready = 1'b1;
      #1;
      vectors++;
      if (outs !== zero_v) begin miscompares++; $display("FAIL midwrite_ready: got %05h expected %05h", outs, zero_v); end
      tick();
      @(negedge clk);
      vectors++;
      if (outs !== zero_v) begin miscompares++; $display("FAIL midwrite_hold: got %05h expected %05h", outs, zero_v); end
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (outs !== zero_v) begin miscompares++; $display("FAIL midwrite_wait: got %05h expected %05h", outs, zero_v); end
      tick();
      @(negedge clk);
      e = mk(6'b111000, 2'b10, 2'b00, 2'b10, 3'b001, 3'b000, 2'b00);
      vectors++;
      if (outs !== e) begin miscompares++; $display("FAIL midwrite_refetch: got %05h expected %05h", outs, e); end
      mem_ready = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_load();
      test_rtype();
      test_itype();
      test_beq(1'b1);
      test_beq(1'b0);
      test_jal();
      test_utype();
      test_illegal();
      test_store();
      test_reset_midwrite();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
